// File: rtl/unified_mem_arbiter_if.sv
// Bundles the core-side request/response signals and the memory-side bus of
// unified_mem_arbiter. The slave modport is the arbiter's view; master is the core/memory view.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              if_stall;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              d_stall;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, if_stall, d_rdata, d_ack, d_stall,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, if_stall, d_rdata, d_ack, d_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Serialises IF and MEM stage accesses onto one fixed-latency memory, data first.
// Define ARB_IFETCH_BUF_EN to add a one-entry fetch buffer that answers repeat fetches in IDLE.
module unified_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  unified_mem_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(MEM_LAT) + 1;
  localparam logic [CNT_W-1:0] WAIT_INIT = (MEM_LAT > 1) ? CNT_W'(MEM_LAT - 2) : '0;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              own_d_q, own_d_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic [DATA_W-1:0] buf_rdata;
  logic              buf_hit, if_resp, d_resp;

  // A fetch response only counts if the core still wants that same address.
  assign if_resp = (state_q == RESP) && !own_d_q && bus.if_req && (bus.if_addr == addr_q);
  assign d_resp  = (state_q == RESP) && own_d_q;

`ifdef ARB_IFETCH_BUF_EN
  logic              buf_vld_q;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [DATA_W-1:0] buf_data_q;

  assign buf_hit   = (state_q == IDLE) && bus.if_req && !bus.d_req &&
                     buf_vld_q && (buf_addr_q == bus.if_addr);
  assign buf_rdata = buf_data_q;

  // Any granted store may alias the buffered line, so drop it unconditionally.
  always_ff @(posedge clk) begin
    if (reset)                                          buf_vld_q <= 1'b0;
    else if ((state_q == IDLE) && bus.d_req && bus.d_we) buf_vld_q <= 1'b0;
    else if (if_resp)                                   buf_vld_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (if_resp) begin
      buf_addr_q <= addr_q;
      buf_data_q <= bus.mem_rdata;
    end
  end
`else
  assign buf_hit   = 1'b0;
  assign buf_rdata = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    own_d_d = own_d_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.d_req) begin
          own_d_d = 1'b1;
          we_d    = bus.d_we;
          addr_d  = bus.d_addr;
          wdata_d = bus.d_wdata;
          state_d = ACCESS;
        end else if (bus.if_req && !buf_hit) begin
          own_d_d = 1'b0;
          we_d    = 1'b0;
          addr_d  = bus.if_addr;
          wdata_d = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (MEM_LAT == 1) begin
          state_d = RESP;
        end else begin
          cnt_d   = WAIT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      own_d_q <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      own_d_q <= own_d_d;
      we_q    <= we_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Response holding registers: keep the last delivered word per requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (if_resp)      if_rdata_q <= bus.mem_rdata;
      else if (buf_hit) if_rdata_q <= buf_rdata;
      if (d_resp && !we_q) d_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.if_ack    = if_resp || buf_hit;
  assign bus.if_rdata  = if_resp ? bus.mem_rdata : (buf_hit ? buf_rdata : if_rdata_q);
  assign bus.if_stall  = bus.if_req && !bus.if_ack;
  assign bus.d_ack     = d_resp;
  assign bus.d_rdata   = (d_resp && !we_q) ? bus.mem_rdata : d_rdata_q;
  assign bus.d_stall   = bus.d_req && !bus.d_ack;
  assign bus.mem_en    = (state_q == ACCESS);
  assign bus.mem_we    = bus.mem_en && we_q;
  assign bus.mem_addr  = bus.mem_en ? addr_q : '0;
  assign bus.mem_wdata = bus.mem_en ? wdata_q : '0;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a MEM_LAT=2 memory model; cycle 0 is the request cycle.
module tb_unified_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    case (a)
      32'h40:  return 32'h00A00893;
      32'h80:  return 32'h12345678;
      32'h100: return 32'hCAFEF00D;
      default: return 32'h0;
    endcase
  endfunction

  logic [DW-1:0] rd_p0 = '0;
  logic [DW-1:0] rd_p1 = '0;
  always @(posedge clk) begin
    rd_p0 <= (bus.mem_en && !bus.mem_we) ? mem_fn(bus.mem_addr) : '0;
    rd_p1 <= rd_p0;
  end
  assign bus.mem_rdata = rd_p1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A pending data request must hold d_req and d_addr until d_ack.
  logic          pend_q  = 1'b0;
  logic [AW-1:0] paddr_q = '0;
  always @(negedge clk) begin
    if (!reset && pend_q) begin
      checks++;
      assert (bus.d_req === 1'b1 && bus.d_addr === paddr_q) else begin
        failures++;
        $error("FAIL d_hold observed=%0h expected=%0h", bus.d_addr, paddr_q);
      end
    end
    pend_q  <= !reset && bus.d_req && !bus.d_ack;
    paddr_q <= bus.d_addr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
  endtask

  task automatic do_reset();
    clr_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_if_ack"}, bus.if_ack, 0);
    chk({tag, "_d_ack"}, bus.d_ack, 0);
    chk({tag, "_if_stall"}, bus.if_stall, 0);
    chk({tag, "_d_stall"}, bus.d_stall, 0);
    chk({tag, "_mem_en"}, bus.mem_en, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_if_rdata"}, bus.if_rdata, 0);
    chk({tag, "_d_rdata"}, bus.d_rdata, 0);
  endtask

  // Full-latency fetch: mem_en in cycle 1, ack in cycle 3, then one cycle with if_req low.
  task automatic run_fetch(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.if_req = 1'b1; bus.if_addr = a;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk({tag, "_mem_en"}, bus.mem_en, (c == 1));
      chk({tag, "_if_ack"}, bus.if_ack, (c == 3));
      chk({tag, "_if_stall"}, bus.if_stall, (c < 3));
      if (c == 1) chk({tag, "_mem_addr"}, bus.mem_addr, a);
      if (c == 3) chk({tag, "_if_rdata"}, bus.if_rdata, d);
      tick();
    end
    bus.if_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    clr_inputs();
    do_reset();
    @(negedge clk);
    chk_zero("rst");
    tick();

    run_fetch("single", 32'h40, 32'h00A00893);
    @(negedge clk);
    chk("single_hold_rdata", bus.if_rdata, 32'h00A00893);
    tick();

    // Simultaneous fetch 0x40 and load 0x100.
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
    for (int c = 0; c < 8; c++) begin
      if (c == 4) bus.d_req = 1'b0;
      @(negedge clk);
      chk("sim_mem_en", bus.mem_en, (c == 1 || c == 5));
      chk("sim_d_ack", bus.d_ack, (c == 3));
      chk("sim_if_ack", bus.if_ack, (c == 7));
      if (c == 1) chk("sim_mem_addr_d", bus.mem_addr, 32'h100);
      if (c == 5) chk("sim_mem_addr_i", bus.mem_addr, 32'h40);
      if (c == 3) chk("sim_d_rdata", bus.d_rdata, 32'hCAFEF00D);
      if (c == 7) chk("sim_if_rdata", bus.if_rdata, 32'h00A00893);
      tick();
    end
    bus.if_req = 1'b0;

    // Store keeps the previous load data in d_rdata.
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = 32'hDEADBEEF;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) begin bus.d_req = 1'b0; bus.d_we = 1'b0; end
      @(negedge clk);
      chk("st_mem_en", bus.mem_en, (c == 1));
      chk("st_mem_we", bus.mem_we, (c == 1));
      chk("st_mem_addr", bus.mem_addr, (c == 1) ? 32'h200 : 32'h0);
      chk("st_mem_wdata", bus.mem_wdata, (c == 1) ? 32'hDEADBEEF : 32'h0);
      chk("st_d_ack", bus.d_ack, (c == 3));
      chk("st_d_rdata", bus.d_rdata, 32'hCAFEF00D);
      tick();
    end

    // Fetch redirect from 0x40 to 0x80 during WAIT.
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    for (int c = 0; c < 8; c++) begin
      if (c == 2) bus.if_addr = 32'h80;
      @(negedge clk);
      chk("rd_if_ack", bus.if_ack, (c == 7));
      chk("rd_mem_en", bus.mem_en, (c == 1 || c == 5));
      if (c == 3) chk("rd_stale_rdata", bus.if_rdata, 32'h0);
      if (c == 5) chk("rd_mem_addr", bus.mem_addr, 32'h80);
      if (c == 7) chk("rd_if_rdata", bus.if_rdata, 32'h12345678);
      tick();
    end
    bus.if_req = 1'b0;

    // Reset pulsed in the WAIT cycle.
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    tick();
    @(negedge clk);
    chk("rm_mem_en_c1", bus.mem_en, 1);
    tick();
    reset = 1'b1; bus.if_req = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk_zero("rm_c3");
    tick();
    @(negedge clk);
    chk_zero("rm_c4");
    tick();

    // Repeat fetch behaviour, with and without the fetch buffer.
    do_reset();
    run_fetch("first", 32'h40, 32'h00A00893);
    @(negedge clk);
    chk("gap_mem_en", bus.mem_en, 0);
    tick();
`ifdef ARB_IFETCH_BUF_EN
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    @(negedge clk);
    chk("hit_if_ack", bus.if_ack, 1);
    chk("hit_if_rdata", bus.if_rdata, 32'h00A00893);
    chk("hit_mem_en", bus.mem_en, 0);
    chk("hit_if_stall", bus.if_stall, 0);
    tick();
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("hit_no_access", bus.mem_en, 0);
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h300; bus.d_wdata = 32'h1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("inv_d_ack", bus.d_ack, (c == 3));
      tick();
    end
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    @(negedge clk);
    tick();
    run_fetch("after_st", 32'h40, 32'h00A00893);
`else
    run_fetch("repeat", 32'h40, 32'h00A00893);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Arbitrates one single-ported, fixed-latency unified memory between the pipeline's IF stage (instruction fetch) and MEM stage (load/store). It sits between the 5-stage CPU core and the backing memory. It serialises accesses, gives data accesses priority, and returns per-requester acknowledge and stall signals that the core's PC-write and pipeline-register enables consume.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from the memory access cycle (mem_en high) to mem_rdata valid; legal range ≥1

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction
- if_ack  out  1  fetch complete, one-cycle pulse
- if_stall  out  1  if_req & ~if_ack
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data
- d_ack  out  1  data complete, one-cycle pulse
- d_stall  out  1  d_req & ~d_ack
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle

## Operation
FSM states:
- IDLE: arbitrate only here.
  - d_req set → grant D (fixed priority, since MEM holds the older instruction).
  - Else if_req set → grant I.
  - Else stay in IDLE.
  - On grant: latch owner, address, we, wdata → ACCESS.
- ACCESS (1 cycle):
  - mem_en=1 and mem_we=latched we; mem_addr and mem_wdata are driven from the latched values.
  - → WAIT, or → RESP if MEM_LAT=1.
- WAIT (MEM_LAT−1 cycles):
  - Down-counter of width $clog2(MEM_LAT)+1.
  - mem_en=0 in this state.
  - → RESP when the count expires.
- RESP (1 cycle):
  - mem_rdata is valid. The owner's ack=1 and its rdata = mem_rdata, passed through combinationally.
  - The owner's rdata register captures mem_rdata and holds it until the next response to that owner.
  - → IDLE.

Rules:
- Stale fetch: in RESP with owner I, if if_req=0 or if_addr ≠ latched address (redirect/flush), then if_ack=0, the data is discarded, and the fetch buffer is not filled.
- Stores: d_ack still pulses in RESP; d_rdata is not updated.
- d_req/d_addr changing mid-transaction is illegal; the bench asserts this never happens.
- Only one transaction is ever outstanding.
- mem_en, mem_we, mem_addr and mem_wdata are all 0 outside ACCESS.

## Timing
- Request in IDLE cycle T → mem_en in T+1 → ack in T+1+MEM_LAT (T+3 at default).
- Re-arbitration occurs in the IDLE cycle after RESP. Throughput is one access per MEM_LAT+2 cycles.
- Simultaneous if_req and d_req in IDLE: the D transaction completes first. I is granted in the following IDLE cycle.
- Reset values:
  - FSM state IDLE, counter 0.
  - All ack, stall and mem_* outputs 0.
  - if_rdata and d_rdata 0.
  - Fetch buffer invalid.
- Reset mid-transaction: the transaction is abandoned with no ack, and mem_en=0 from the next cycle.
- The stall outputs are purely combinational from req and ack.

## Configuration
- ARB_IFETCH_BUF_EN defined: adds a one-entry fetch buffer {valid, addr, data}.
  - Hit: in IDLE with if_req=1, d_req=0, valid=1 and addr==if_addr → if_ack=1 and if_rdata=buffered data in the same cycle. No memory access is made and the FSM stays in IDLE.
  - Fill: on every non-stale fetch RESP.
  - Invalidate: on reset and on any granted store (any address).
  - d_req still has priority over a buffer hit.
- Undefined: no buffer exists; every fetch takes the full latency.

## Test plan
- Single fetch, MEM_LAT=2: if_req in cycle 0 with if_addr=0x40; memory returns 0x00A00893 → mem_en=1 only in cycle 1; if_ack=1 only in cycle 3 with if_rdata=0x00A00893; if_stall=1 in cycles 0–2.
- Simultaneous requests in cycle 0, fetch 0x40 and load 0x100 → mem_addr=0x100 in cycle 1; d_ack in cycle 3; mem_addr=0x40 in cycle 5; if_ack in cycle 7.
- Store with d_addr=0x200, d_wdata=0xDEADBEEF → mem_we=1, mem_addr=0x200, mem_wdata=0xDEADBEEF only in cycle 1; d_ack in cycle 3; d_rdata unchanged.
- Fetch redirect: if_addr changes from 0x40 to 0x80 in cycle 2 → no ack in cycle 3; IDLE in cycle 4; mem_addr=0x80 in cycle 5; if_ack in cycle 7.
- Reset pulsed in the WAIT cycle (cycle 2) → no ack in cycle 3; all outputs 0; the FSM stays in IDLE.
- ARB_IFETCH_BUF_EN defined:
  - A repeat fetch of 0x40 after it completes → if_ack in the request cycle with no mem_en.
  - After a store to 0x300, a fetch of 0x40 → full latency of 3 cycles.
  - With ARB_IFETCH_BUF_EN undefined, a repeat fetch also takes 3 cycles.
